// File: rtl/codec_cfg_sequencer.sv
// Codec register-configuration sequencer: runs the power-up init table over the
// shared I2C master, then arbitrates runtime single-register writes.
// Optional build macro: CODEC_CFG_RETRY_EN (NACK retry with MAX_RETRY resends).
module codec_cfg_sequencer #(
  parameter int STARTUP_CYC = 1000,
  parameter int GAP_CYC = 16,
  parameter logic [7:0] DEV_ADDR = 8'h34
`ifdef CODEC_CFG_RETRY_EN
  , parameter int MAX_RETRY = 3
`endif
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iSTART,
  input  logic        iREQ,
  input  logic [6:0]  iREQ_ADDR,
  input  logic [8:0]  iREQ_DATA,
  output logic        oREQ_ACK,
  output logic        oREQ_ERR,
  output logic        oI2C_GO,
  output logic [23:0] oI2C_DATA,
  input  logic        iI2C_END,
  input  logic        iI2C_ACK,
  output logic        oBUSY,
  output logic        oCFG_DONE,
  output logic        oERR
);

  localparam logic [2:0] ST_STARTUP = 3'd0;
  localparam logic [2:0] ST_SEND    = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_GAP     = 3'd3;
  localparam logic [2:0] ST_READY   = 3'd4;
  localparam logic [2:0] ST_ERROR   = 3'd5;

  localparam logic [3:0]  LAST_IDX     = 4'd10;
  localparam logic [15:0] STARTUP_LAST = 16'(STARTUP_CYC - 1);
  localparam logic [15:0] GAP_LAST     = 16'(GAP_CYC - 1);

  // {reg[6:0], data[8:0]} for each init step
  function automatic logic [15:0] init_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    init_entry = {7'd15, 9'h000};
      4'd1:    init_entry = {7'd6,  9'h000};
      4'd2:    init_entry = {7'd0,  9'h017};
      4'd3:    init_entry = {7'd1,  9'h017};
      4'd4:    init_entry = {7'd2,  9'h079};
      4'd5:    init_entry = {7'd3,  9'h079};
      4'd6:    init_entry = {7'd4,  9'h012};
      4'd7:    init_entry = {7'd5,  9'h000};
      4'd8:    init_entry = {7'd7,  9'h001};
      4'd9:    init_entry = {7'd8,  9'h000};
      4'd10:   init_entry = {7'd9,  9'h001};
      default: init_entry = 16'h0000;
    endcase
  endfunction

  logic [2:0]  state_r;
  logic [15:0] cnt_r;
  logic [3:0]  idx_r;
  logic        is_rt_r;
  logic [15:0] rt_frame_r;
  logic        resend_r;
  logic        start_pend_r;
  logic        i2c_go_r;
  logic [23:0] i2c_data_r;
  logic        req_ack_r;
  logic        req_err_r;
  logic        busy_r;
  logic        cfg_done_r;
  logic        err_r;

  logic gap_exit_s;
  logic start_now_s;
  logic new_send_s;
  logic retry_inc_s;
  logic retry_ok_s;

  assign gap_exit_s  = (state_r == ST_GAP) && (cnt_r == GAP_LAST);
  assign start_now_s = start_pend_r | iSTART;
  // Any transition into SEND that begins a fresh entry or request
  assign new_send_s  = ((state_r == ST_STARTUP) && (cnt_r == STARTUP_LAST)) ||
                       ((state_r == ST_READY) && (iSTART || iREQ)) ||
                       ((state_r == ST_ERROR) && iSTART) ||
                       (gap_exit_s && (start_now_s || !resend_r));
  assign retry_inc_s = (state_r == ST_WAIT) && iI2C_END && !iI2C_ACK && retry_ok_s;

`ifdef CODEC_CFG_RETRY_EN
  logic [7:0] retry_r;
  assign retry_ok_s = (retry_r < 8'(MAX_RETRY));

  // Resend counter for the entry or request currently in flight
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      retry_r <= 8'd0;
    end else if (new_send_s) begin
      retry_r <= 8'd0;
    end else if (retry_inc_s) begin
      retry_r <= retry_r + 8'd1;
    end else begin
      retry_r <= retry_r;
    end
  end
`else
  assign retry_ok_s = 1'b0;
`endif

  // Sequencer FSM with all outputs registered on the transitions
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_r      <= ST_STARTUP;
      cnt_r        <= 16'd0;
      idx_r        <= 4'd0;
      is_rt_r      <= 1'b0;
      rt_frame_r   <= 16'd0;
      resend_r     <= 1'b0;
      start_pend_r <= 1'b0;
      i2c_go_r     <= 1'b0;
      i2c_data_r   <= 24'd0;
      req_ack_r    <= 1'b0;
      req_err_r    <= 1'b0;
      busy_r       <= 1'b1;
      cfg_done_r   <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      req_ack_r <= 1'b0;
      req_err_r <= 1'b0;
      if (iSTART && ((state_r == ST_SEND) || (state_r == ST_WAIT) || (state_r == ST_GAP))) begin
        start_pend_r <= 1'b1;
      end
      case (state_r)
        ST_STARTUP: begin
          if (cnt_r == STARTUP_LAST) begin
            cnt_r   <= 16'd0;
            idx_r   <= 4'd0;
            is_rt_r <= 1'b0;
            state_r <= ST_SEND;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_SEND: begin
          i2c_go_r   <= 1'b1;
          i2c_data_r <= {DEV_ADDR, is_rt_r ? rt_frame_r : init_entry(idx_r)};
          state_r    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (iI2C_END) begin
            i2c_go_r <= 1'b0;
            cnt_r    <= 16'd0;
            if (iI2C_ACK) begin
              resend_r  <= 1'b0;
              req_ack_r <= is_rt_r;
              state_r   <= ST_GAP;
            end else if (retry_ok_s) begin
              resend_r <= 1'b1;
              state_r  <= ST_GAP;
            end else if (is_rt_r) begin
              resend_r  <= 1'b0;
              req_ack_r <= 1'b1;
              req_err_r <= 1'b1;
              state_r   <= ST_GAP;
            end else begin
              // A failed init entry is terminal; a restart needs a fresh iSTART
              err_r        <= 1'b1;
              busy_r       <= 1'b0;
              start_pend_r <= 1'b0;
              state_r      <= ST_ERROR;
            end
          end
        end
        ST_GAP: begin
          if (gap_exit_s) begin
            cnt_r    <= 16'd0;
            resend_r <= 1'b0;
            if (start_now_s) begin
              start_pend_r <= 1'b0;
              cfg_done_r   <= 1'b0;
              is_rt_r      <= 1'b0;
              idx_r        <= 4'd0;
              state_r      <= ST_SEND;
            end else if (resend_r) begin
              state_r <= ST_SEND;
            end else if (is_rt_r || (idx_r == LAST_IDX)) begin
              cfg_done_r <= cfg_done_r | !is_rt_r;
              busy_r     <= 1'b0;
              state_r    <= ST_READY;
            end else begin
              idx_r   <= idx_r + 4'd1;
              state_r <= ST_SEND;
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_READY: begin
          if (iSTART) begin
            cfg_done_r <= 1'b0;
            idx_r      <= 4'd0;
            is_rt_r    <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= ST_SEND;
          end else if (iREQ) begin
            rt_frame_r <= {iREQ_ADDR, iREQ_DATA};
            is_rt_r    <= 1'b1;
            busy_r     <= 1'b1;
            state_r    <= ST_SEND;
          end
        end
        ST_ERROR: begin
          if (iSTART) begin
            err_r   <= 1'b0;
            idx_r   <= 4'd0;
            is_rt_r <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= ST_SEND;
          end
        end
        default: begin
          state_r  <= ST_STARTUP;
          cnt_r    <= 16'd0;
          i2c_go_r <= 1'b0;
          busy_r   <= 1'b1;
        end
      endcase
    end
  end

  assign oREQ_ACK  = req_ack_r;
  assign oREQ_ERR  = req_err_r;
  assign oI2C_GO   = i2c_go_r;
  assign oI2C_DATA = i2c_data_r;
  assign oBUSY     = busy_r;
  assign oCFG_DONE = cfg_done_r;
  assign oERR      = err_r;

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Directed bench for codec_cfg_sequencer: scenario table plus hand-written
// sequences for runtime writes, start/request collision and mid-frame reset.
module tb_codec_cfg_sequencer;

  localparam int STARTUP_CYC = 8;
  localparam int GAP_CYC = 4;
  localparam int FRAME_CYC = 3;
`ifdef CODEC_CFG_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  logic        iCLK = 1'b0;
  logic        iRST_N = 1'b0;
  logic        iSTART = 1'b0;
  logic        iREQ = 1'b0;
  logic [6:0]  iREQ_ADDR = 7'd0;
  logic [8:0]  iREQ_DATA = 9'd0;
  logic        oREQ_ACK;
  logic        oREQ_ERR;
  logic        oI2C_GO;
  logic [23:0] oI2C_DATA;
  logic        iI2C_END;
  logic        iI2C_ACK;
  logic        oBUSY;
  logic        oCFG_DONE;
  logic        oERR;

  codec_cfg_sequencer #(.STARTUP_CYC(STARTUP_CYC), .GAP_CYC(GAP_CYC), .DEV_ADDR(8'h34)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iSTART(iSTART), .iREQ(iREQ),
    .iREQ_ADDR(iREQ_ADDR), .iREQ_DATA(iREQ_DATA), .oREQ_ACK(oREQ_ACK),
    .oREQ_ERR(oREQ_ERR), .oI2C_GO(oI2C_GO), .oI2C_DATA(oI2C_DATA),
    .iI2C_END(iI2C_END), .iI2C_ACK(iI2C_ACK), .oBUSY(oBUSY),
    .oCFG_DONE(oCFG_DONE), .oERR(oERR)
  );

  always #10 iCLK = ~iCLK;

  int checks = 0;
  int errors = 0;

  logic [23:0] init_tab [0:10];
  logic [23:0] frame_log [0:63];
  logic [23:0] exp_seq [0:63];
  int exp_n;
  int n_frames = 0;
  int frame_cyc = 0;
  int ack_cnt = 0;
  int stable_viol = 0;
  logic [23:0] nack_frame = 24'h0;
  int nack_limit = 0;
  int nacks_used = 0;
  logic prev_go = 1'b0;
  logic [23:0] prev_data = 24'h0;

  typedef struct {
    logic [23:0] nack_frame;
    int          nack_limit;
    int          exp_frames;
    logic        exp_done;
    logic        exp_err;
  } scen_t;
  scen_t scen [0:2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // I2C master model: ends each frame FRAME_CYC cycles after GO, logs it, ACKs unless told to NACK
  initial begin
    iI2C_END = 1'b0;
    iI2C_ACK = 1'b0;
    forever begin
      @(negedge iCLK);
      iI2C_END = 1'b0;
      iI2C_ACK = 1'b0;
      if (oREQ_ACK === 1'b1) ack_cnt++;
      if (oI2C_GO === 1'b1 && prev_go && oI2C_DATA !== prev_data) stable_viol++;
      prev_go = (oI2C_GO === 1'b1);
      prev_data = oI2C_DATA;
      if (oI2C_GO === 1'b1) begin
        if (frame_cyc == FRAME_CYC - 1) begin
          iI2C_END = 1'b1;
          if (oI2C_DATA == nack_frame && nacks_used < nack_limit) begin
            nacks_used++;
            iI2C_ACK = 1'b0;
          end else begin
            iI2C_ACK = 1'b1;
          end
          if (n_frames < 64) frame_log[n_frames] = oI2C_DATA;
          n_frames++;
          frame_cyc = 0;
        end else begin
          frame_cyc++;
        end
      end else begin
        frame_cyc = 0;
      end
    end
  end

  task automatic do_reset();
    iRST_N = 1'b0;
    iSTART = 1'b0;
    iREQ = 1'b0;
    repeat (2) @(negedge iCLK);
    check("rst_go", {31'd0, oI2C_GO}, 32'd0);
    check("rst_data", {8'd0, oI2C_DATA}, 32'd0);
    check("rst_ack", {30'd0, oREQ_ACK, oREQ_ERR}, 32'd0);
    check("rst_done_err", {30'd0, oCFG_DONE, oERR}, 32'd0);
    check("rst_busy", {31'd0, oBUSY}, 32'd1);
    n_frames = 0;
    nacks_used = 0;
    iRST_N = 1'b1;
  endtask

  task automatic wait_done_or_err(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge iCLK);
      if (oCFG_DONE === 1'b1 || oERR === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_req_ack(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge iCLK);
      if (oREQ_ACK === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_frames(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge iCLK);
      if (n_frames >= target) ok = 1'b1;
    end
  endtask

  // Expected frame sequence for an init run against the NACK setting of the model
  task automatic build_exp(input logic [23:0] nf, input int lim);
    int used;
    int fails;
    bit stop;
    bit next;
    exp_n = 0;
    used = 0;
    stop = 1'b0;
    for (int e = 0; e < 11 && !stop; e++) begin
      fails = 0;
      next = 1'b0;
      while (!next && !stop) begin
        exp_seq[exp_n] = init_tab[e];
        exp_n++;
        if (init_tab[e] == nf && used < lim) begin
          used++;
          if (RETRY_EN && fails < 3) fails++;
          else stop = 1'b1;
        end else begin
          next = 1'b1;
        end
      end
    end
  endtask

  task automatic check_init_seq(input int base);
    for (int k = 0; k < 11; k++) check($sformatf("init_frame_%0d", k), {8'd0, frame_log[base + k]}, {8'd0, init_tab[k]});
  endtask

  initial begin
    bit ok;
    int base;
    int acks0;
    int go_hi;
    init_tab[0] = 24'h341E00; init_tab[1] = 24'h340C00; init_tab[2] = 24'h340017;
    init_tab[3] = 24'h340217; init_tab[4] = 24'h340479; init_tab[5] = 24'h340679;
    init_tab[6] = 24'h340812; init_tab[7] = 24'h340A00; init_tab[8] = 24'h340E01;
    init_tab[9] = 24'h341000; init_tab[10] = 24'h341201;

    scen[0] = '{24'h000000, 0, 11, 1'b1, 1'b0};
`ifdef CODEC_CFG_RETRY_EN
    scen[1] = '{24'h340017, 1, 12, 1'b1, 1'b0};
    scen[2] = '{24'h340479, 1000, 8, 1'b0, 1'b1};
`else
    scen[1] = '{24'h340017, 1, 3, 1'b0, 1'b1};
    scen[2] = '{24'h340479, 1000, 5, 1'b0, 1'b1};
`endif

    for (int s = 0; s < 3; s++) begin
      nack_frame = scen[s].nack_frame;
      nack_limit = scen[s].nack_limit;
      do_reset();
      repeat (STARTUP_CYC - 3) @(negedge iCLK);
      check($sformatf("s%0d_startup_quiet", s), {31'd0, oI2C_GO}, 32'd0);
      wait_done_or_err(ok);
      check($sformatf("s%0d_finish_timeout", s), {31'd0, ok}, 32'd1);
      repeat (2) @(negedge iCLK);
      check($sformatf("s%0d_done", s), {31'd0, oCFG_DONE}, {31'd0, scen[s].exp_done});
      check($sformatf("s%0d_err", s), {31'd0, oERR}, {31'd0, scen[s].exp_err});
      check($sformatf("s%0d_busy", s), {31'd0, oBUSY}, 32'd0);
      check($sformatf("s%0d_frames", s), n_frames, scen[s].exp_frames);
      build_exp(scen[s].nack_frame, scen[s].nack_limit);
      for (int k = 0; k < exp_n && k < n_frames; k++)
        check($sformatf("s%0d_frame_%0d", s, k), {8'd0, frame_log[k]}, {8'd0, exp_seq[k]});
      if (scen[s].exp_err) begin
        go_hi = 0;
        repeat (20) begin
          @(negedge iCLK);
          if (oI2C_GO !== 1'b0) go_hi++;
        end
        check($sformatf("s%0d_go_low_in_error", s), go_hi, 0);
        nack_limit = 0;
        base = n_frames;
        iSTART = 1'b1;
        @(negedge iCLK);
        iSTART = 1'b0;
        check($sformatf("s%0d_err_cleared", s), {31'd0, oERR}, 32'd0);
        wait_frames(base + 1, ok);
        check($sformatf("s%0d_restart_timeout", s), {31'd0, ok}, 32'd1);
        check($sformatf("s%0d_restart_frame", s), {8'd0, frame_log[base]}, 32'h00341E00);
      end
    end

    // Runtime request raised mid-init waits for init to finish
    nack_limit = 0;
    do_reset();
    wait_frames(3, ok);
    check("mid_req_frames_timeout", {31'd0, ok}, 32'd1);
    acks0 = ack_cnt;
    iREQ_ADDR = 7'h04;
    iREQ_DATA = 9'h008;
    iREQ = 1'b1;
    wait_done_or_err(ok);
    check("mid_req_done_timeout", {31'd0, ok}, 32'd1);
    check("mid_req_frames_at_done", n_frames, 11);
    check_init_seq(0);
    wait_req_ack(ok);
    iREQ = 1'b0;
    check("mid_req_ack_timeout", {31'd0, ok}, 32'd1);
    check("mid_req_err", {31'd0, oREQ_ERR}, 32'd0);
    check("mid_req_frame_count", n_frames, 12);
    check("mid_req_frame", {8'd0, frame_log[11]}, 32'h00340808);
    repeat (20) @(negedge iCLK);
    check("mid_req_single_ack", ack_cnt - acks0, 1);
    check("mid_req_ready", {30'd0, oBUSY, oCFG_DONE}, 32'd1);

    // iSTART and iREQ in the same READY cycle: init first, then the write
    base = n_frames;
    iREQ_ADDR = 7'h05;
    iREQ_DATA = 9'h1FF;
    iREQ = 1'b1;
    iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    check("coll_done_cleared", {31'd0, oCFG_DONE}, 32'd0);
    wait_req_ack(ok);
    iREQ = 1'b0;
    check("coll_ack_timeout", {31'd0, ok}, 32'd1);
    check("coll_frame_count", n_frames - base, 12);
    check_init_seq(base);
    check("coll_rt_frame", {8'd0, frame_log[base + 11]}, 32'h00340BFF);
    check("coll_done_kept", {31'd0, oCFG_DONE}, 32'd1);
    repeat (10) @(negedge iCLK);

    // Request latency from READY: GO rises on the second edge
    iREQ_ADDR = 7'h06;
    iREQ_DATA = 9'h000;
    iREQ = 1'b1;
    @(negedge iCLK);
    check("lat_go_edge1", {31'd0, oI2C_GO}, 32'd0);
    @(negedge iCLK);
    check("lat_go_edge2", {31'd0, oI2C_GO}, 32'd1);
    check("lat_data", {8'd0, oI2C_DATA}, 32'h00340C00);
    wait_req_ack(ok);
    iREQ = 1'b0;
    check("lat_ack_timeout", {31'd0, ok}, 32'd1);
    repeat (10) @(negedge iCLK);

    // One-cycle reset while entry 5 is in WAIT
    do_reset();
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge iCLK);
      if (oI2C_GO === 1'b1 && oI2C_DATA == 24'h340679) ok = 1'b1;
    end
    check("rstw_reach_e5", {31'd0, ok}, 32'd1);
    iRST_N = 1'b0;
    @(negedge iCLK);
    iRST_N = 1'b1;
    check("rstw_go_dropped", {31'd0, oI2C_GO}, 32'd0);
    check("rstw_busy", {31'd0, oBUSY}, 32'd1);
    n_frames = 0;
    repeat (STARTUP_CYC - 3) @(negedge iCLK);
    check("rstw_startup_quiet", n_frames, 0);
    wait_done_or_err(ok);
    check("rstw_done_timeout", {31'd0, ok}, 32'd1);
    check("rstw_frames", n_frames, 11);
    check_init_seq(0);

    check("data_stable_with_go", stable_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/codec_cfg_sequencer.md
# codec_cfg_sequencer

Sequences the audio codec's register configuration over the I2C master and shares that I2C master between the power-up init sequence and runtime single-register writes from user logic, such as mute/bypass changes driven by the selector. It sits between user logic and the I2C master in the top level, on the 50 MHz clock domain. It owns the codec's control path only; the serial audio datapath is untouched.

## Interface
- STARTUP_CYC, 1000: idle cycles after reset release before init begins automatically.
- GAP_CYC, 16: minimum idle cycles between consecutive I2C transactions.
- DEV_ADDR, 8'h34: codec write address, sent as the first frame byte.
- MAX_RETRY, 3: retries per transaction after a NACK (see Configuration).
- iCLK  in  1  system clock, 50 MHz; all logic on the rising edge.
- iRST_N  in  1  reset, synchronous, active-low.
- iSTART  in  1  one-cycle pulse; re-runs the full init sequence.
- iREQ  in  1  runtime write request, level; held until oREQ_ACK.
- iREQ_ADDR  in  7  runtime register address.
- iREQ_DATA  in  9  runtime register data.
- oREQ_ACK  out  1  one-cycle pulse when the runtime transaction finishes.
- oREQ_ERR  out  1  valid with oREQ_ACK; 1 = transaction failed.
- oI2C_GO  out  1  transaction request to the I2C master, level.
- oI2C_DATA  out  24  frame {DEV_ADDR, reg[6:0], data[8:0]}.
- iI2C_END  in  1  one-cycle pulse from the I2C master: frame finished.
- iI2C_ACK  in  1  sampled with iI2C_END; 1 = all three bytes were acknowledged.
- oBUSY  out  1  any transaction or gap is in progress.
- oCFG_DONE  out  1  init sequence completed without error.
- oERR  out  1  init sequence aborted.

## Operation
- Init table is an internal constant of 11 entries, {reg, data}, sent in index order:
  - 0: R15 = 0x000 (reset)
  - 1: R6 = 0x000 (power)
  - 2: R0 = 0x017
  - 3: R1 = 0x017
  - 4: R2 = 0x079
  - 5: R3 = 0x079
  - 6: R4 = 0x012
  - 7: R5 = 0x000
  - 8: R7 = 0x001
  - 9: R8 = 0x000
  - 10: R9 = 0x001 (active)
- States:
  - STARTUP: counts STARTUP_CYC cycles, then goes to SEND with index 0.
  - SEND: drives oI2C_DATA, raises oI2C_GO, goes to WAIT.
  - WAIT: holds oI2C_GO and oI2C_DATA until iI2C_END.
    - iI2C_ACK=1: goes to GAP.
    - NACK: if the retry count < MAX_RETRY, increments it and goes to GAP, then resends the same entry.
    - NACK with retries exhausted: goes to ERROR for an init entry, or completes the request with oREQ_ERR=1 for a runtime write.
  - GAP: counts GAP_CYC cycles, then:
    - next init index, or READY after index 10 (oCFG_DONE is set on that transition);
    - READY after a runtime write, with oREQ_ACK pulsed at GAP entry.
  - READY: iSTART clears oCFG_DONE and goes to SEND with index 0. Otherwise iREQ latches iREQ_ADDR/iREQ_DATA and goes to SEND.
  - ERROR: oERR=1. iSTART clears oERR and restarts init at index 0. iREQ is ignored.
- The retry count clears at every new entry or request.
- Arbitration:
  - Init has absolute priority. iREQ is only accepted in READY and stays pending otherwise.
  - iSTART and iREQ in the same READY cycle: iSTART wins and iREQ stays pending.
  - iSTART during SEND, WAIT or GAP is latched. It takes effect at the next GAP exit in place of the normal next step. A frame is never aborted.
  - iSTART during STARTUP is ignored.
- oBUSY = 1 in every state except READY and ERROR.

## Timing
- Reset values: oI2C_GO=0, oI2C_DATA=0, oREQ_ACK=0, oREQ_ERR=0, oCFG_DONE=0, oERR=0, oBUSY=1, state STARTUP with the counter cleared.
- Reset in any state returns to STARTUP on the next edge and drops oI2C_GO immediately.
- All outputs are registered.
- oI2C_GO rises 1 cycle after SEND entry and falls on the cycle after iI2C_END is sampled.
- oI2C_DATA is stable whenever oI2C_GO=1.
- iI2C_END while not in WAIT is ignored.
- A runtime request is accepted in READY on the cycle iREQ is seen. oI2C_GO rises 2 cycles later.
- oREQ_ACK is a single cycle; the requester drops iREQ after it.
- iREQ still high at the GAP exit after oREQ_ACK is a new request. It is accepted on the first READY cycle.
- Init latency without NACKs: STARTUP_CYC + 11 × (2 + I2C frame time + GAP_CYC) cycles, ±1 per entry.

## Configuration
- CODEC_CFG_RETRY_EN defined: NACK retry per Operation, up to MAX_RETRY resends.
- CODEC_CFG_RETRY_EN undefined:
  - the first NACK is final (init goes to ERROR, runtime gets oREQ_ERR=1);
  - MAX_RETRY is unused and no retry counter is built.

## Test plan
- Reset, STARTUP_CYC=8, I2C model always ACKs:
  - 11 frames appear in table order;
  - first frame is 24'h341E00, last is 24'h341201;
  - oCFG_DONE=1, oBUSY=0 afterwards.
- NACK on entry 2, first attempt only, retry enabled: entry 2 is resent exactly once, init completes, oERR=0.
- Entry 4 always NACKs:
  - with retry: 4 attempts, then oERR=1 and oI2C_GO stays low;
  - without retry: 1 attempt, then oERR=1;
  - iSTART then restarts at frame 24'h341E00.
- iREQ addr=7'h04 data=9'h008 raised mid-init: no early frame; after init completes, frame 24'h340808 is sent, followed by one oREQ_ACK with oREQ_ERR=0.
- iSTART and iREQ in the same READY cycle: the init sequence runs first, then the runtime frame.
- iRST_N low for 1 cycle during WAIT of entry 5: oI2C_GO=0 next cycle, and STARTUP then the full sequence from entry 0 follow.
